dual_port_sram: RTL and testbench

//  True dual-port synchronous SRAM: two independent read/write ports (A, B)

---
 rtl/dual_port_sram.sv | 36 +++
 tb/tb_dual_port_sram.sv | 110 +++++++++++
 2 files changed

// File: rtl/dual_port_sram.sv
// dual_port_sram: true dual-port synchronous RAM with registered, write-through read data.
module dual_port_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic        [ADDR_WIDTH-1:0] addr_a,
  input  logic signed [DATA_WIDTH-1:0] data_a,
  input  logic                         we_a,
  output logic signed [DATA_WIDTH-1:0] q_a,
  input  logic        [ADDR_WIDTH-1:0] addr_b,
  input  logic signed [DATA_WIDTH-1:0] data_b,
  input  logic                         we_b,
  output logic signed [DATA_WIDTH-1:0] q_b
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  // Port A is written last so it wins when both ports write the same word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_b) r_mem[addr_b] <= data_b;
      if (we_a) r_mem[addr_a] <= data_a;
    end
  end
  // Reads see the array before this edge's writes, giving read-before-write across ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= we_a ? data_a : r_mem[addr_a];
      q_b <= we_b ? data_b : r_mem[addr_b];
    end
  end
endmodule

// File: tb/tb_dual_port_sram.sv
// tb_dual_port_sram: directed scoreboard bench for dual_port_sram.
module tb_dual_port_sram;
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [31:0] q_a, q_b;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] mm[16];
  bit          mv[16];

  dual_port_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic wa, input logic [3:0] aa, input logic [31:0] da,
                      input logic wb, input logic [3:0] ab, input logic [31:0] db);
    exp_t e;
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    if (wa) sb_a.push_back('{{tag, "/a"}, da});
    else if (mv[aa]) sb_a.push_back('{{tag, "/a"}, mm[aa]});
    if (wb) sb_b.push_back('{{tag, "/b"}, db});
    else if (mv[ab]) sb_b.push_back('{{tag, "/b"}, mm[ab]});
    if (wb) begin mm[ab] = db; mv[ab] = 1'b1; end
    if (wa) begin mm[aa] = da; mv[aa] = 1'b1; end
    @(posedge clk);
    #1;
    while (sb_a.size() > 0) begin e = sb_a.pop_front(); chk(e.tag, q_a, e.v); end
    while (sb_b.size() > 0) begin e = sb_b.pop_front(); chk(e.tag, q_b, e.v); end
  endtask

  initial begin
    #1;
    chk("por_q_a", q_a, 32'h0);
    chk("por_q_b", q_b, 32'h0);
    #12 rst_n = 1'b1;
    // Port A only: write then read back
    step("a_wr0", 1, 4'd0, 32'h12345678, 0, 4'd1, 0);
    step("a_wr4", 1, 4'd4, 32'hDEADBEEF, 0, 4'd1, 0);
    step("a_wr8", 1, 4'd8, 32'h00000001, 0, 4'd1, 0);
    step("a_wr12", 1, 4'd12, 32'h80000000, 0, 4'd1, 0);
    step("a_rd0", 0, 4'd0, 0, 0, 4'd1, 0);
    step("a_rd4", 0, 4'd4, 0, 0, 4'd1, 0);
    step("a_rd8", 0, 4'd8, 0, 0, 4'd1, 0);
    step("a_rd12", 0, 4'd12, 0, 0, 4'd1, 0);
    // Both ports writing, then reading
    step("dp_wr1", 1, 4'd0, 32'hA5A5A5A5, 1, 4'd8, 32'h5A5A5A5A);
    step("dp_wr2", 1, 4'd4, 32'h11111111, 1, 4'd12, 32'h22222222);
    step("dp_rd1", 0, 4'd0, 0, 0, 4'd8, 0);
    step("dp_rd2", 0, 4'd4, 0, 0, 4'd12, 0);
    // Cross-port read
    step("x_wr3", 1, 4'd3, 32'hCAFEF00D, 0, 4'd0, 0);
    step("x_rd3", 0, 4'd0, 0, 0, 4'd3, 0);
    chk("x_rd3_const", q_b, 32'hCAFEF00D);
    // Same-address write collision
    step("wc_wr5", 1, 4'd5, 32'h1, 1, 4'd5, 32'h2);
    step("wc_rd5", 0, 4'd5, 0, 0, 4'd5, 0);
    chk("wc_a_wins", q_b, 32'h1);
    // Read/write collision
    step("rw_init6", 1, 4'd6, 32'h7, 0, 4'd0, 0);
    step("rw_coll6", 1, 4'd6, 32'h9, 0, 4'd6, 0);
    chk("rw_old_b", q_b, 32'h7);
    step("rw_new6", 0, 4'd4, 0, 0, 4'd6, 0);
    chk("rw_new_b", q_b, 32'h9);
    // Asynchronous reset mid-run with q_a nonzero
    chk("pre_rst_q_a", q_a, 32'h11111111);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_q_a", q_a, 32'h0);
    chk("rst_async_q_b", q_b, 32'h0);
    we_a = 1'b1; addr_a = 4'd0; data_a = 32'hFFFFFFFF;
    we_b = 1'b1; addr_b = 4'd8; data_b = 32'hEEEEEEEE;
    @(posedge clk);
    #1;
    chk("rst_hold_q_a", q_a, 32'h0);
    chk("rst_hold_q_b", q_b, 32'h0);
    we_a = 1'b0; we_b = 1'b0;
    rst_n = 1'b1;
    // Contents retained and writes during reset ignored
    step("post_rst", 0, 4'd0, 0, 0, 4'd8, 0);
    chk("retain_a", q_a, 32'hA5A5A5A5);
    chk("retain_b", q_b, 32'h5A5A5A5A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
